cdc_tx_arbiter: RTL

//  Source-side (left-domain) controller for the CDC req/ack channel. It shares one crossing

---
 rtl/cdc_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/cdc_tx_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the left-domain CDC transmit controller.
package cdc_pkg;

    typedef enum logic [1:0] {
        CDC_IDLE,
        CDC_REQ,
        CDC_REL
    } cdc_tx_state_e;

    // Source-ID width: enough bits to name N requesters, never narrower than 1.
    function automatic int cdc_id_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from N-1 back to 0. ptr is assumed to be in range [0, N-1].
module rr_arbiter
    import cdc_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = cdc_id_w(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    int idx;

    // Walk the N candidates in priority order starting at ptr; keep the first hit.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_id     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Left-domain source controller for the CDC req/ack channel: round-robin
// arbitration over N requesters, then a full four-phase handshake per word.
module cdc_tx_arbiter
    import cdc_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = cdc_id_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*W-1:0]     in_data,
    output logic               cdc_req,
    input  logic               cdc_ack,
    output logic [IDW+W-1:0]   cdc_data,
    output logic               busy,
    output logic [IDW-1:0]     grant_id
);

    cdc_tx_state_e      state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               cdc_req_q, cdc_req_d;
    logic [IDW+W-1:0]   cdc_data_q, cdc_data_d;

    logic [N-1:0]       arb_gnt;
    logic [IDW-1:0]     arb_id;
    logic               arb_any;
    logic               take;

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
        .req    (in_valid),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // A grant needs an idle channel and a low ack; a stale high ack after
    // reset therefore holds off the first transfer until it clears.
    assign take = (state_q == CDC_IDLE) && !cdc_ack && arb_any;

    // Accept strobe is held low during reset even though the FSM sits in IDLE.
    assign in_ready = (rst_n && take) ? arb_gnt : '0;
    assign busy     = (state_q != CDC_IDLE);
    assign cdc_req  = cdc_req_q;
    assign cdc_data = cdc_data_q;
    assign grant_id = grant_id_q;

    // Next-state: latch winner on grant, then only advance on the expected ack level.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        cdc_req_d  = cdc_req_q;
        cdc_data_d = cdc_data_q;
        case (state_q)
            CDC_IDLE: begin
                if (take) begin
                    cdc_data_d = {arb_id, in_data[int'(arb_id)*W +: W]};
                    grant_id_d = arb_id;
                    cdc_req_d  = 1'b1;
                    // Explicit wrap so non-power-of-2 N never lets ptr reach N.
                    ptr_d      = (arb_id == IDW'(N-1)) ? '0 : arb_id + IDW'(1);
                    state_d    = CDC_REQ;
                end
            end
            CDC_REQ: begin
                if (cdc_ack) begin
                    cdc_req_d = 1'b0;
                    state_d   = CDC_REL;
                end
            end
            CDC_REL: begin
                if (!cdc_ack) state_d = CDC_IDLE;
            end
            default: begin
                cdc_req_d = 1'b0;
                state_d   = CDC_IDLE;
            end
        endcase
    end

    // State, pointer and output registers; async reset drops any open transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CDC_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            cdc_req_q  <= 1'b0;
            cdc_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            cdc_req_q  <= cdc_req_d;
            cdc_data_q <= cdc_data_d;
        end
    end

endmodule
